tag_rx_integ_dump: RTL and testbench
====================================

// Module: tag_rx_integ_dump
// PURPOSE
// Downstream of the tag RX control stage: consumes its de-rotated baseband IQ (irx/qrx_out_bb),
// frame valid (rx_valid) and sync-segment flag (rx_out_mux). Skips the sync preamble, then
// integrates-and-dumps SAMP_PER_SYMB samples per symbol for NSYMB symbols. Emits per-symbol I/Q sums
// through a small FIFO on a valid/ready stream with tlast on the final symbol.
// PARAMETERS
// DATA_WIDTH      16    signed I/Q sample width
// ACC_WIDTH       32    signed accumulator / output width; must be >= DATA_WIDTH+clog2(SAMP_PER_SYMB)
// NSYMB_WIDTH     16    symbol index width
// NSYMB           64    symbols per frame
// CNT_WIDTH       16    sample counter width
// SAMP_PER_SYMB   8000  samples integrated per symbol (>=2)
// FIFO_AW         2     output FIFO address width (depth 2**FIFO_AW)
// PORTS
// clk          in   1            clock
// reset        in   1            asynchronous, active-high reset
// irx_in       in   DATA_WIDTH   signed baseband I
// qrx_in       in   DATA_WIDTH   signed baseband Q
// in_valid     in   1            frame valid (tag RX valid); one sample per cycle while high
// in_sync      in   1            high while samples belong to the sync preamble
// out_i        out  ACC_WIDTH    per-symbol I sum
// out_q        out  ACC_WIDTH    per-symbol Q sum
// out_symb     out  NSYMB_WIDTH  symbol index 0..NSYMB-1
// out_tvalid   out  1            FIFO not empty
// out_tlast    out  1            entry is symbol NSYMB-1
// out_tready   in   1            consumer accepts when out_tvalid&out_tready
// overflow     out  1            sticky: a symbol was dropped on a full FIFO
// state        out  2            debug: 00 IDLE, 01 SYNC, 10 ACQ, 11 DONE
// BEHAVIOUR
// - Reset (async): state=IDLE, accumulators/counters=0, FIFO empty, out_tvalid=0, out_tlast=0,
//   out_i/out_q/out_symb=0, overflow=0.
// - IDLE: in_valid&in_sync -> SYNC, clear overflow, symbol count=0. in_valid&~in_sync stays IDLE.
// - SYNC: samples ignored. ~in_valid -> IDLE. in_valid&~in_sync -> ACQ; that sample is sample 0 of
//   symbol 0 (accumulated).
// - ACQ: per in_valid cycle, acc_i/q += sign-extended sample; sample count increments. On sample
//   SAMP_PER_SYMB-1: dump acc+sample to FIFO with current symbol index, reload acc=0, count=0,
//   symbol++. Dump of symbol NSYMB-1 sets tlast and moves to DONE.
// - ACQ, in_sync reasserted: partial symbol discarded, no dump, -> SYNC, symbol count=0.
// - ACQ, in_valid low: partial symbol discarded, no dump, no tlast, -> IDLE.
// - DONE: inputs ignored until ~in_valid -> IDLE.
// - Arithmetic two's complement; accumulator wraps silently if ACC_WIDTH is undersized.
// - Latency: sum of a symbol is visible (out_tvalid=1) the cycle after its last sample was sampled.
// - FIFO: first-word-fall-through; outputs driven from head entry; pop on out_tvalid&out_tready.
// - Full FIFO at dump: write accepted only if a pop occurs the same cycle; otherwise symbol dropped,
//   overflow<=1, symbol index still advances (tlast on NSYMB-1 can be lost).
// - Empty FIFO with simultaneous write: entry appears next cycle; no same-cycle bypass.
// - FIFO contents survive frame end/restart and drain normally; only reset flushes.
// - out_i/out_q/out_symb/out_tlast hold while out_tvalid&~out_tready.
// TESTING (bench: SAMP_PER_SYMB=4, NSYMB=3, FIFO_AW=2)
// 1 in_valid=1, in_sync=1 for 5 cyc, then 12 samples I=100,Q=-50, tready=1 -> 3 outputs I=400,Q=-200,
//   symb 0,1,2, tlast only on symb 2, state ends DONE, then IDLE after in_valid low.
// 2 Same with I=32767 ramp/-32768 mix: I=32767,-32768,32767,-32768 -> out_i=-2 (exact signed sum).
// 3 tready=0 whole frame, FIFO_AW=1 (depth 2) -> symb 0,1 held, symb 2 dropped, overflow=1, no tlast;
//   then tready=1 drains exactly 2 entries.
// 4 in_valid drops after 6 ACQ samples -> 1 output (symb 0), partial discarded, state IDLE; next
//   frame starts at symb 0 and clears overflow.
// 5 in_sync reasserted after 5 ACQ samples, then 12 clean samples -> 1st symb 0 from aborted frame,
//   then symb 0,1,2 with tlast.
// 6 reset pulsed mid-ACQ with 2 entries queued -> out_tvalid=0 immediately (async), state=IDLE.

Source files
------------

// File: rtl/tag_rx_integ_dump.sv
// Integrate-and-dump of tag RX baseband after the sync preamble. Emits one I/Q
// sum per symbol through a small first-word-fall-through FIFO on a valid/ready stream.
module tag_rx_integ_dump #(
    parameter int DATA_WIDTH    = 16,
    parameter int ACC_WIDTH     = 32,
    parameter int NSYMB_WIDTH   = 16,
    parameter int NSYMB         = 64,
    parameter int CNT_WIDTH     = 16,
    parameter int SAMP_PER_SYMB = 8000,
    parameter int FIFO_AW       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [DATA_WIDTH-1:0]  irx_in,
    input  logic signed [DATA_WIDTH-1:0]  qrx_in,
    input  logic                          in_valid,
    input  logic                          in_sync,
    output logic signed [ACC_WIDTH-1:0]   out_i,
    output logic signed [ACC_WIDTH-1:0]   out_q,
    output logic [NSYMB_WIDTH-1:0]        out_symb,
    output logic                          out_tvalid,
    output logic                          out_tlast,
    input  logic                          out_tready,
    output logic                          overflow,
    output logic [1:0]                    state
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CNT_WIDTH-1:0]   LAST_SAMP = CNT_WIDTH'(SAMP_PER_SYMB - 1);
    localparam logic [NSYMB_WIDTH-1:0] LAST_SYMB = NSYMB_WIDTH'(NSYMB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SYNC = 2'b01,
        S_ACQ  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    typedef struct packed {
        logic signed [ACC_WIDTH-1:0] i;
        logic signed [ACC_WIDTH-1:0] q;
        logic [NSYMB_WIDTH-1:0]      symb;
        logic                        last;
    } entry_t;

    typedef logic [FIFO_AW:0] ptr_t;

    state_e                       state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic [NSYMB_WIDTH-1:0]       symb_q, symb_d;
    logic                         ovf_q, ovf_d;
    entry_t                       mem_q [DEPTH];
    ptr_t                         wr_ptr_q, rd_ptr_q;

    logic signed [ACC_WIDTH-1:0]  samp_i, samp_q, sum_i, sum_q;
    logic                         push_req, fifo_we, pop, full;
    entry_t                       push_entry, head;

    assign samp_i = {{(ACC_WIDTH-DATA_WIDTH){irx_in[DATA_WIDTH-1]}}, irx_in};
    assign samp_q = {{(ACC_WIDTH-DATA_WIDTH){qrx_in[DATA_WIDTH-1]}}, qrx_in};
    assign sum_i  = acc_i_q + samp_i;
    assign sum_q  = acc_q_q + samp_q;

    assign out_tvalid = (wr_ptr_q != rd_ptr_q);
    assign full       = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop        = out_tvalid & out_tready;
    // A full FIFO still takes the write if the head leaves in the same cycle.
    assign fifo_we    = push_req & (~full | pop);

    always_comb begin
        state_d    = state_q;
        acc_i_d    = acc_i_q;
        acc_q_d    = acc_q_q;
        cnt_d      = cnt_q;
        symb_d     = symb_q;
        ovf_d      = ovf_q;
        push_req   = 1'b0;
        push_entry = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_sync) begin
                    state_d = S_SYNC;
                    ovf_d   = 1'b0;
                    symb_d  = '0;
                    acc_i_d = '0;
                    acc_q_d = '0;
                    cnt_d   = '0;
                end
            end
            S_SYNC: begin
                if (!in_valid) begin
                    state_d = S_IDLE;
                end else if (!in_sync) begin
                    state_d = S_ACQ;
                    acc_i_d = samp_i;
                    acc_q_d = samp_q;
                    cnt_d   = CNT_WIDTH'(1);
                    symb_d  = '0;
                end
            end
            S_ACQ: begin
                if (!in_valid || in_sync) begin
                    state_d = in_valid ? S_SYNC : S_IDLE;
                    acc_i_d = '0;
                    acc_q_d = '0;
                    cnt_d   = '0;
                    if (in_valid) symb_d = '0;
                end else if (cnt_q == LAST_SAMP) begin
                    push_req        = 1'b1;
                    push_entry.i    = sum_i;
                    push_entry.q    = sum_q;
                    push_entry.symb = symb_q;
                    push_entry.last = (symb_q == LAST_SYMB);
                    acc_i_d         = '0;
                    acc_q_d         = '0;
                    cnt_d           = '0;
                    symb_d          = symb_q + NSYMB_WIDTH'(1);
                    if (symb_q == LAST_SYMB) state_d = S_DONE;
                end else begin
                    acc_i_d = sum_i;
                    acc_q_d = sum_q;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_DONE: begin
                if (!in_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (push_req && !fifo_we) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            cnt_q    <= '0;
            symb_q   <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else begin
            state_q <= state_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            cnt_q   <= cnt_d;
            symb_q  <= symb_d;
            ovf_q   <= ovf_d;
            if (fifo_we) begin
                mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_entry;
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + ptr_t'(1);
        end
    end

    assign head      = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign out_i     = head.i;
    assign out_q     = head.q;
    assign out_symb  = head.symb;
    assign out_tlast = out_tvalid & head.last;
    assign overflow  = ovf_q;
    assign state     = state_q;

endmodule

// File: tb/tb_tag_rx_integ_dump.sv
// Bench for tag_rx_integ_dump: two instances (FIFO depth 4 and 2) share the input
// stream; a frame/sample-list model with queue FIFOs predicts every output cycle.
module tb_tag_rx_integ_dump;

    localparam int SPS = 4;
    localparam int NS  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [15:0] irx = '0, qrx = '0;
    logic vld = 1'b0, syn = 1'b0;
    logic rdy [2];
    logic signed [31:0] o_i [2];
    logic signed [31:0] o_q [2];
    logic [15:0] o_s [2];
    logic o_v [2], o_l [2], o_ov [2];
    logic [1:0] o_st [2];

    always #5 clk = ~clk;

    tag_rx_integ_dump #(.DATA_WIDTH(16), .ACC_WIDTH(32), .NSYMB_WIDTH(16), .NSYMB(NS),
        .CNT_WIDTH(16), .SAMP_PER_SYMB(SPS), .FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .irx_in(irx), .qrx_in(qrx), .in_valid(vld), .in_sync(syn),
        .out_i(o_i[0]), .out_q(o_q[0]), .out_symb(o_s[0]), .out_tvalid(o_v[0]),
        .out_tlast(o_l[0]), .out_tready(rdy[0]), .overflow(o_ov[0]), .state(o_st[0]));

    tag_rx_integ_dump #(.DATA_WIDTH(16), .ACC_WIDTH(32), .NSYMB_WIDTH(16), .NSYMB(NS),
        .CNT_WIDTH(16), .SAMP_PER_SYMB(SPS), .FIFO_AW(1)) dut1 (
        .clk(clk), .reset(reset), .irx_in(irx), .qrx_in(qrx), .in_valid(vld), .in_sync(syn),
        .out_i(o_i[1]), .out_q(o_q[1]), .out_symb(o_s[1]), .out_tvalid(o_v[1]),
        .out_tlast(o_l[1]), .out_tready(rdy[1]), .overflow(o_ov[1]), .state(o_st[1]));

    typedef struct {
        int i;
        int q;
        int symb;
        bit last;
    } exp_t;

    exp_t mq0[$];
    exp_t mq1[$];
    bit   mov [2];
    int   fi[$];
    int   fq[$];
    bit   synced;
    bit   rrand;
    int   ntests, nfail;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp_v);
        ntests++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_outs();
        exp_t q[$];
        for (int k = 0; k < 2; k++) begin
            if (k == 0) q = mq0; else q = mq1;
            chk($sformatf("d%0d.tvalid", k), o_v[k], (q.size() != 0));
            chk($sformatf("d%0d.overflow", k), o_ov[k], mov[k]);
            if (q.size() != 0) begin
                chk($sformatf("d%0d.out_i", k), o_i[k], q[0].i);
                chk($sformatf("d%0d.out_q", k), o_q[k], q[0].q);
                chk($sformatf("d%0d.out_symb", k), o_s[k], q[0].symb);
                chk($sformatf("d%0d.tlast", k), o_l[k], q[0].last);
            end
        end
    endtask

    // Frame-level view: samples after the last sync are grouped in chunks of SPS;
    // the first NS chunks become symbols, anything later is ignored.
    task automatic model_edge();
        bit   dump = 1'b0;
        exp_t e;
        exp_t q[$];
        bit   full, pop;
        e = '{0, 0, 0, 1'b0};
        if (!vld) begin
            synced = 1'b0;
            fi.delete(); fq.delete();
        end else if (syn) begin
            if (!synced) begin
                synced = 1'b1;
                mov[0] = 1'b0; mov[1] = 1'b0;
                fi.delete(); fq.delete();
            end else if (fi.size() < SPS*NS) begin
                fi.delete(); fq.delete();
            end
        end else if (synced && fi.size() < SPS*NS) begin
            fi.push_back(int'(irx));
            fq.push_back(int'(qrx));
            if (fi.size() % SPS == 0) begin
                dump = 1'b1;
                for (int j = fi.size() - SPS; j < fi.size(); j++) begin
                    e.i += fi[j];
                    e.q += fq[j];
                end
                e.symb = fi.size() / SPS - 1;
                e.last = (e.symb == NS - 1);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 0) q = mq0; else q = mq1;
            full = (q.size() == ((k == 0) ? 4 : 2));
            pop  = (q.size() != 0) && rdy[k];
            if (pop) void'(q.pop_front());
            if (dump) begin
                if (!full || pop) q.push_back(e);
                else mov[k] = 1'b1;
            end
            if (k == 0) mq0 = q; else mq1 = q;
        end
    endtask

    task automatic cyc(input bit v, input bit s, input logic signed [15:0] i,
                       input logic signed [15:0] q);
        vld = v; syn = s; irx = i; qrx = q;
        if (rrand) begin
            rdy[0] = 1'($urandom_range(0, 1));
            rdy[1] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check_outs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_n(input int n);
        for (int c = 0; c < n; c++) cyc(1'b1, 1'b1, 16'sd0, 16'sd0);
    endtask

    task automatic idle_n(input int n);
        for (int c = 0; c < n; c++) cyc(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    task automatic data_fixed(input int n, input logic signed [15:0] i,
                              input logic signed [15:0] q);
        for (int c = 0; c < n; c++) cyc(1'b1, 1'b0, i, q);
    endtask

    task automatic data_rand(input int n);
        for (int c = 0; c < n; c++) cyc(1'b1, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    initial begin
        ntests = 0; nfail = 0;
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        rrand = 1'b0; synced = 1'b0;
        mov[0] = 1'b0; mov[1] = 1'b0;
        #12;
        chk("rst.tvalid", o_v[0], 0);
        chk("rst.tlast", o_l[0], 0);
        chk("rst.out_i", o_i[0], 0);
        chk("rst.out_q", o_q[0], 0);
        chk("rst.out_symb", o_s[0], 0);
        chk("rst.overflow", o_ov[0], 0);
        chk("rst.state", o_st[0], 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // constant frame, streaming consumer; DONE ignores further input
        idle_n(2);
        sync_n(5);
        data_fixed(12, 16'sd100, -16'sd50);
        chk("t1.state_done", o_st[0], 3);
        data_fixed(2, 16'sd7, 16'sd7);
        cyc(1'b1, 1'b1, 16'sd0, 16'sd0);
        chk("t1.state_still_done", o_st[0], 3);
        idle_n(1);
        chk("t1.state_idle", o_st[0], 0);
        idle_n(2);

        // full-scale extremes
        sync_n(3);
        for (int j = 0; j < 12; j++)
            cyc(1'b1, 1'b0, (j % 2 == 0) ? 16'sd32767 : -16'sd32768, 16'($urandom));
        idle_n(3);

        // stalled consumer: depth-2 instance drops symbol 2
        rdy[0] = 1'b0; rdy[1] = 1'b0;
        sync_n(2);
        data_rand(12);
        idle_n(1);
        chk("t3.d1_overflow", o_ov[1], 1);
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        idle_n(5);
        chk("t3.drained", o_v[0], 0);

        // frame cut short by in_valid falling
        sync_n(2);
        chk("t4.ovf_cleared", o_ov[1], 0);
        data_rand(6);
        idle_n(1);
        chk("t4.state_idle", o_st[0], 0);
        idle_n(3);

        // sync reasserted mid-symbol restarts at symbol 0
        sync_n(2);
        data_rand(5);
        sync_n(2);
        data_rand(12);
        idle_n(3);

        // random frames with random back-pressure
        rrand = 1'b1;
        for (int f = 0; f < 8; f++) begin
            sync_n($urandom_range(1, 3));
            data_rand($urandom_range(3, 14));
            if ($urandom_range(0, 1) == 1) begin
                sync_n(1);
                data_rand($urandom_range(2, 13));
            end
            idle_n($urandom_range(1, 4));
        end
        rrand = 1'b0;
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        idle_n(6);

        // async reset with entries queued
        rdy[0] = 1'b0; rdy[1] = 1'b0;
        sync_n(2);
        data_rand(9);
        reset = 1'b1;
        vld = 1'b0;
        #1;
        chk("t6.tvalid0", o_v[0], 0);
        chk("t6.tvalid1", o_v[1], 0);
        chk("t6.state", o_st[0], 0);
        mq0.delete(); mq1.delete();
        mov[0] = 1'b0; mov[1] = 1'b0;
        synced = 1'b0;
        fi.delete(); fq.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        idle_n(2);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
